// File: rtl/mmio_bus_bridge.sv
// mmio_bus_bridge: address decoder and read mux that sits behind the CPU memory
// port. Accesses below PERIPH_BASE go to the external data RAM. Accesses at or
// above it hit the on-chip peripheral registers: timer (TH/TL/TCON), LEDs,
// 7-segment digits and a free-running systick counter.
//
// Optional build macro: SEG_SCAN_EN. When it is defined, DIGITS is 16 bits wide
// and holds four hex nibbles, and the module scans them onto the display
// hardware. When it is undefined, digits mirrors DIGITS[11:0] directly.
//
// Ports:
//   clk                - system clock
//   reset              - asynchronous, active-low reset
//   MemRead            - CPU read strobe
//   MemWrite           - CPU write strobe
//   MemBus_Address     - byte address; bits [1:0] are ignored
//   MemBus_Write_Data  - CPU store data
//   MemBus_Read_Data   - load data to the CPU, combinational (zero latency)
//   ram_we / ram_re    - data RAM write / read enables, combinational decode
//   ram_rdata          - data RAM read data, combinational
//   leds               - LED register
//   digits             - {an[3:0], seg[7:0]} display drive
//   irq                - timer interrupt request (TCON[2])
module mmio_bus_bridge #(
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
  parameter int unsigned SCAN_DIV    = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] MemBus_Read_Data,
  output logic        ram_we,
  output logic        ram_re,
  input  logic [31:0] ram_rdata,
  output logic [7:0]  leds,
  output logic [11:0] digits,
  output logic        irq
);

  localparam int unsigned DataW = 32;
  localparam int unsigned IdxW  = 30;
  localparam int unsigned TconW = 3;
  localparam int unsigned LedW  = 8;
`ifdef SEG_SCAN_EN
  localparam int unsigned DigW  = 16;
`else
  localparam int unsigned DigW  = 12;
`endif

  // Word index of each peripheral register within the window.
  localparam logic [IdxW-1:0] IdxTh      = IdxW'(0);
  localparam logic [IdxW-1:0] IdxTl      = IdxW'(1);
  localparam logic [IdxW-1:0] IdxTcon    = IdxW'(2);
  localparam logic [IdxW-1:0] IdxLeds    = IdxW'(3);
  localparam logic [IdxW-1:0] IdxDigits  = IdxW'(4);
  localparam logic [IdxW-1:0] IdxSystick = IdxW'(5);

  // A zero divider would never wrap; reject it when the block is elaborated.
  if (SCAN_DIV == 0) begin : gBadScanDiv
    $error("mmio_bus_bridge: SCAN_DIV must be nonzero");
  end

  logic [DataW-1:0] thReg;
  logic [DataW-1:0] tlReg;
  logic [TconW-1:0] tconReg;   // {irqStatus, intEn, timEn}
  logic [LedW-1:0]  ledsReg;
  logic [DigW-1:0]  digitsReg;
  logic [DataW-1:0] systickReg;

  logic [DataW-1:0] periphOffset;
  logic [IdxW-1:0]  regIdx;
  logic             selPeriph;
  logic             wrTh, wrTl, wrTcon, wrLeds, wrDigits;
  logic             timEn, intEn, tlOverflow;
  logic [DataW-1:0] periphData;
  logic             unusedBits;

  // Address decode.
  assign selPeriph    = (MemBus_Address >= PERIPH_BASE);
  assign periphOffset = MemBus_Address - PERIPH_BASE;
  assign regIdx       = periphOffset[DataW-1:2];
  assign unusedBits   = &{1'b0, periphOffset[1:0]};

  assign ram_we = MemWrite & ~selPeriph;
  assign ram_re = MemRead  & ~selPeriph;

  assign wrTh     = MemWrite & selPeriph & (regIdx == IdxTh);
  assign wrTl     = MemWrite & selPeriph & (regIdx == IdxTl);
  assign wrTcon   = MemWrite & selPeriph & (regIdx == IdxTcon);
  assign wrLeds   = MemWrite & selPeriph & (regIdx == IdxLeds);
  assign wrDigits = MemWrite & selPeriph & (regIdx == IdxDigits);

  assign timEn      = tconReg[0];
  assign intEn      = tconReg[1];
  assign tlOverflow = timEn & (tlReg == {DataW{1'b1}});

  // Peripheral read mux; unmapped offsets read as zero.
  always_comb begin
    periphData = '0;
    case (regIdx)
      IdxTh:      periphData = thReg;
      IdxTl:      periphData = tlReg;
      IdxTcon:    periphData = DataW'(tconReg);
      IdxLeds:    periphData = DataW'(ledsReg);
      IdxDigits:  periphData = DataW'(digitsReg);
      IdxSystick: periphData = systickReg;
      default:    periphData = '0;
    endcase
  end

  // Zero-latency load path; the MEM stage latches this in the same cycle.
  always_comb begin
    MemBus_Read_Data = '0;
    if (MemRead) begin
      MemBus_Read_Data = selPeriph ? periphData : ram_rdata;
    end
  end

  // Peripheral registers and timer. A CPU write always takes priority over the
  // timer's own update in the same cycle. A TH write still lets TL reload with
  // the old TH, because TL samples thReg before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thReg      <= '0;
      tlReg      <= '0;
      tconReg    <= '0;
      ledsReg    <= '0;
      digitsReg  <= '0;
      systickReg <= '0;
    end else begin
      systickReg <= systickReg + DataW'(1);

      if (wrTh) begin
        thReg <= MemBus_Write_Data;
      end

      if (wrTl) begin
        tlReg <= MemBus_Write_Data;
      end else if (tlOverflow) begin
        tlReg <= thReg;
      end else if (timEn) begin
        tlReg <= tlReg + DataW'(1);
      end

      // irqStatus is sticky until software rewrites TCON.
      if (wrTcon) begin
        tconReg <= MemBus_Write_Data[TconW-1:0];
      end else if (tlOverflow && intEn) begin
        tconReg[2] <= 1'b1;
      end

      if (wrLeds) begin
        ledsReg <= MemBus_Write_Data[LedW-1:0];
      end

      if (wrDigits) begin
        digitsReg <= MemBus_Write_Data[DigW-1:0];
      end
    end
  end

  assign leds = ledsReg;
  assign irq  = tconReg[2];

`ifdef SEG_SCAN_EN
  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DivW-1:0] divCnt;
  logic [1:0]      scanIdx;
  logic [11:0]     digitsOut;
  logic [3:0]      anNext;
  logic [3:0]      nibble;
  logic [6:0]      segNext;

  // Active-low hex-to-7-segment decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hexToSeg(input logic [3:0] hex);
    case (hex)
      4'h0: hexToSeg = 7'b1000000;
      4'h1: hexToSeg = 7'b1111001;
      4'h2: hexToSeg = 7'b0100100;
      4'h3: hexToSeg = 7'b0110000;
      4'h4: hexToSeg = 7'b0011001;
      4'h5: hexToSeg = 7'b0010010;
      4'h6: hexToSeg = 7'b0000010;
      4'h7: hexToSeg = 7'b1111000;
      4'h8: hexToSeg = 7'b0000000;
      4'h9: hexToSeg = 7'b0010000;
      4'hA: hexToSeg = 7'b0001000;
      4'hB: hexToSeg = 7'b0000011;
      4'hC: hexToSeg = 7'b1000110;
      4'hD: hexToSeg = 7'b0100001;
      4'hE: hexToSeg = 7'b0000110;
      default: hexToSeg = 7'b0001110;
    endcase
  endfunction

  // Current digit's anode and segment pattern.
  always_comb begin
    anNext  = ~(4'b0001 << scanIdx);
    nibble  = digitsReg[4*scanIdx +: 4];
    segNext = hexToSeg(nibble);
  end

  // Scan divider, digit index and registered display drive (dp held off).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divCnt    <= '0;
      scanIdx   <= '0;
      digitsOut <= {4'b1110, 1'b1, 7'b1000000};
    end else begin
      if (divCnt == DivW'(SCAN_DIV - 1)) begin
        divCnt  <= '0;
        scanIdx <= scanIdx + 2'd1;
      end else begin
        divCnt <= divCnt + DivW'(1);
      end
      digitsOut <= {anNext, 1'b1, segNext};
    end
  end

  assign digits = digitsOut;
`else
  assign digits = digitsReg;
`endif

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Directed self-checking bench for mmio_bus_bridge. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the inputs change, while the
// clock is still low.
`timescale 1ns/100ps
module tb_mmio_bus_bridge;

  localparam logic [31:0] ATh      = 32'h4000_0000;
  localparam logic [31:0] ATl      = 32'h4000_0004;
  localparam logic [31:0] ATcon    = 32'h4000_0008;
  localparam logic [31:0] ALeds    = 32'h4000_000C;
  localparam logic [31:0] ADigits  = 32'h4000_0010;
  localparam logic [31:0] ASystick = 32'h4000_0014;
  localparam logic [31:0] AHole    = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic [31:0] MemBus_Read_Data;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        irq;

  int nCompared   = 0;
  int nMismatched = 0;
  logic        lastRamWe;
  logic [31:0] rd;
  logic [31:0] s0;

  mmio_bus_bridge dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemBus_Address(MemBus_Address), .MemBus_Write_Data(MemBus_Write_Data),
    .MemBus_Read_Data(MemBus_Read_Data), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .leds(leds), .digits(digits), .irq(irq)
  );

  always #10 clk = ~clk;

  // Called just after a falling edge; spans exactly one rising edge.
  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; MemBus_Address = a; MemBus_Write_Data = d;
    #1 lastRamWe = ram_we;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  // Zero-cycle read; does not cross a clock edge.
  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    MemRead = 1'b1; MemBus_Address = a;
    #1 d = MemBus_Read_Data;
    MemRead = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    MemBus_Address = '0; MemBus_Write_Data = '0; ram_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    busRead(ASystick, rd);
    nCompared++; if (rd !== 32'd10) begin nMismatched++; $display("FAIL reset_systick: got %0d expected 10", rd); end
    nCompared++; if (leds !== 8'h00) begin nMismatched++; $display("FAIL reset_leds: got %h expected 00", leds); end
    nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("FAIL reset_irq: got %b expected 0", irq); end
    nCompared++; if (digits !== 12'h000) begin nMismatched++; $display("FAIL reset_digits: got %h expected 000", digits); end
    busRead(ATh, rd);
    nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("FAIL reset_th: got %h expected 0", rd); end
    @(negedge clk);
  endtask

  task automatic test_timer;
    busWrite(ATh, 32'hFFFF_FFFC);
    busWrite(ATl, 32'hFFFF_FFFE);
    busWrite(ATcon, 32'd3);
    busRead(ATl, rd);
    nCompared++; if (rd !== 32'hFFFF_FFFE) begin nMismatched++; $display("FAIL timer_tl_start: got %h expected FFFFFFFE", rd); end
    @(negedge clk);
    busRead(ATl, rd);
    nCompared++; if (rd !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL timer_tl_max: got %h expected FFFFFFFF", rd); end
    nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("FAIL timer_irq_pre: got %b expected 0", irq); end
    @(negedge clk);
    busRead(ATl, rd);
    nCompared++; if (rd !== 32'hFFFF_FFFC) begin nMismatched++; $display("FAIL timer_reload: got %h expected FFFFFFFC", rd); end
    nCompared++; if (irq !== 1'b1) begin nMismatched++; $display("FAIL timer_irq_set: got %b expected 1", irq); end
    repeat (4) @(negedge clk);
    busRead(ATl, rd);
    nCompared++; if (rd !== 32'hFFFF_FFFC) begin nMismatched++; $display("FAIL timer_reload2: got %h expected FFFFFFFC", rd); end
    nCompared++; if (irq !== 1'b1) begin nMismatched++; $display("FAIL timer_irq_sticky: got %b expected 1", irq); end
    busRead(ATcon, rd);
    nCompared++; if (rd !== 32'd7) begin nMismatched++; $display("FAIL timer_tcon_read: got %h expected 7", rd); end
    @(negedge clk);
    busWrite(ATcon, 32'd0);
    nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("FAIL timer_irq_clear: got %b expected 0", irq); end
    busRead(ATl, rd);
    nCompared++; if (rd !== 32'hFFFF_FFFE) begin nMismatched++; $display("FAIL timer_tl_stop: got %h expected FFFFFFFE", rd); end
    @(negedge clk);
    busRead(ATl, rd);
    nCompared++; if (rd !== 32'hFFFF_FFFE) begin nMismatched++; $display("FAIL timer_tl_hold: got %h expected FFFFFFFE", rd); end
    @(negedge clk);
  endtask

  task automatic test_race;
    busWrite(ATh, 32'h0000_0010);
    busWrite(ATl, 32'hFFFF_FFFE);
    busWrite(ATcon, 32'd3);
    @(negedge clk);
    busWrite(ATcon, 32'd1);
    nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("FAIL race_tcon_irq: got %b expected 0", irq); end
    busRead(ATcon, rd);
    nCompared++; if (rd !== 32'd1) begin nMismatched++; $display("FAIL race_tcon_val: got %h expected 1", rd); end
    busRead(ATl, rd);
    nCompared++; if (rd !== 32'h10) begin nMismatched++; $display("FAIL race_reload: got %h expected 10", rd); end
    @(negedge clk);
    busWrite(ATl, 32'hFFFF_FFFF);
    busRead(ATl, rd);
    nCompared++; if (rd !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL race_tl_write: got %h expected FFFFFFFF", rd); end
    busWrite(ATh, 32'h55);
    busRead(ATl, rd);
    nCompared++; if (rd !== 32'h10) begin nMismatched++; $display("FAIL race_th_old: got %h expected 10", rd); end
    busRead(ATh, rd);
    nCompared++; if (rd !== 32'h55) begin nMismatched++; $display("FAIL race_th_new: got %h expected 55", rd); end
    @(negedge clk);
    busWrite(ATcon, 32'd0);
  endtask

  task automatic test_leds_ram;
    busWrite(ALeds, 32'h0000_00A5);
    nCompared++; if (lastRamWe !== 1'b0) begin nMismatched++; $display("FAIL leds_ram_we: got %b expected 0", lastRamWe); end
    nCompared++; if (leds !== 8'hA5) begin nMismatched++; $display("FAIL leds_value: got %h expected A5", leds); end
    busWrite(32'h0000_0010, 32'h0000_0077);
    nCompared++; if (lastRamWe !== 1'b1) begin nMismatched++; $display("FAIL ram_we_pulse: got %b expected 1", lastRamWe); end
    #1;
    nCompared++; if (ram_we !== 1'b0) begin nMismatched++; $display("FAIL ram_we_drop: got %b expected 0", ram_we); end
    nCompared++; if (leds !== 8'hA5) begin nMismatched++; $display("FAIL leds_kept: got %h expected A5", leds); end
    ram_rdata = 32'hCAFE_F00D;
    busRead(32'h0000_0010, rd);
    nCompared++; if (rd !== 32'hCAFE_F00D) begin nMismatched++; $display("FAIL ram_read: got %h expected CAFEF00D", rd); end
    MemBus_Address = ALeds; #1;
    nCompared++; if (MemBus_Read_Data !== 32'h0) begin nMismatched++; $display("FAIL idle_read_zero: got %h expected 0", MemBus_Read_Data); end
    nCompared++; if (ram_re !== 1'b0) begin nMismatched++; $display("FAIL ram_re_idle: got %b expected 0", ram_re); end
    @(negedge clk);
`ifndef SEG_SCAN_EN
    busWrite(ADigits, 32'hFFFF_FABC);
    nCompared++; if (digits !== 12'hABC) begin nMismatched++; $display("FAIL digits_value: got %h expected ABC", digits); end
    busRead(ADigits, rd);
    nCompared++; if (rd !== 32'h0000_0ABC) begin nMismatched++; $display("FAIL digits_read: got %h expected ABC", rd); end
`endif
    busWrite(ATcon, 32'hFFFF_FFF8);
    busRead(ATcon, rd);
    nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("FAIL tcon_mask: got %h expected 0", rd); end
    @(negedge clk);
  endtask

  task automatic test_systick;
    busRead(ASystick, s0);
    busWrite(ASystick, 32'h1234_5678);
    busRead(ASystick, rd);
    nCompared++; if (rd !== s0 + 32'd1) begin nMismatched++; $display("FAIL systick_ro: got %h expected %h", rd, s0 + 32'd1); end
    busWrite(AHole, 32'h1234_5678);
    busRead(ASystick, rd);
    nCompared++; if (rd !== s0 + 32'd2) begin nMismatched++; $display("FAIL systick_hole: got %h expected %h", rd, s0 + 32'd2); end
    busRead(AHole, rd);
    nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("FAIL hole_read: got %h expected 0", rd); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    MemRead = 1'b1;
    busWrite(ALeds, 32'h0000_003C);
    MemRead = 1'b1; MemBus_Address = ALeds;
    #1 rd = MemBus_Read_Data;
    MemRead = 1'b0;
    nCompared++; if (rd !== 32'h3C) begin nMismatched++; $display("FAIL rw_post: got %h expected 3C", rd); end
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b1; MemBus_Address = ALeds; MemBus_Write_Data = 32'h0000_0081;
    #1 rd = MemBus_Read_Data;
    nCompared++; if (rd !== 32'h3C) begin nMismatched++; $display("FAIL rw_pre_edge: got %h expected 3C", rd); end
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    nCompared++; if (leds !== 8'h81) begin nMismatched++; $display("FAIL rw_write: got %h expected 81", leds); end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    busWrite(ATcon, 32'd7);
    nCompared++; if (irq !== 1'b1) begin nMismatched++; $display("FAIL areset_irq_pre: got %b expected 1", irq); end
    #3 reset = 1'b0;
    #1;
    nCompared++; if (leds !== 8'h00) begin nMismatched++; $display("FAIL areset_leds: got %h expected 00", leds); end
    nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("FAIL areset_irq: got %b expected 0", irq); end
    busRead(ASystick, rd);
    nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("FAIL areset_systick: got %h expected 0", rd); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_timer();
    test_race();
    test_leds_ram();
    test_systick();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
